// File: rtl/heartbeat_generator.sv
// Heartbeat source for the watchdog: converts host activity strobes into a
// rate-limited single-cycle pulse train, with stale-activity cutoff and hold-off.
module heartbeat_generator #(
  parameter int HB_PERIOD   = 1000000,
  parameter int ACT_TIMEOUT = 4000000,
  parameter int HOLDOFF     = 256,
  parameter int CNT_W       = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        activity,
  input  logic        force_reset,
  output logic        heartbeat,
  output logic        alive,
  output logic [1:0]  state,
  output logic [15:0] hb_count
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_ACT = 2'd1,
    S_ALIVE    = 2'd2,
    S_HOLDOFF  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] PERIOD_LAST  = CNT_W'(HB_PERIOD - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ACT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLDOFF - 1);

  state_t           r_state;
  logic             r_heartbeat;
  logic             r_alive;
  logic [15:0]      r_hb_count;
  logic [CNT_W-1:0] r_period_cnt;
  logic [CNT_W-1:0] r_idle_cnt;
  logic [CNT_W-1:0] r_hold_cnt;

  state_t           w_state_next;
  logic             w_hb_next;
  logic [CNT_W-1:0] w_period_next;
  logic [CNT_W-1:0] w_idle_next;
  logic [CNT_W-1:0] w_hold_next;

  always_comb begin
    w_state_next  = r_state;
    w_hb_next     = 1'b0;
    w_period_next = '0;
    w_idle_next   = '0;
    w_hold_next   = '0;
    if (!enable) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_next = S_WAIT_ACT;
        end
        S_WAIT_ACT: begin
          if (force_reset) begin
            w_state_next = S_HOLDOFF;
          end else if (activity) begin
            w_state_next = S_ALIVE;
            w_hb_next    = 1'b1;
          end
        end
        S_ALIVE: begin
          if (force_reset) begin
            w_state_next = S_HOLDOFF;
          end else if (r_idle_cnt == TIMEOUT_LAST && !activity) begin
            // Stale host: stop pulsing even if the period also expires now.
            w_state_next = S_WAIT_ACT;
          end else begin
            w_hb_next     = (r_period_cnt == PERIOD_LAST);
            w_period_next = w_hb_next ? '0 : r_period_cnt + 1'b1;
            w_idle_next   = activity ? '0 : r_idle_cnt + 1'b1;
          end
        end
        S_HOLDOFF: begin
          if (force_reset) begin
            w_hold_next = '0;
          end else if (r_hold_cnt == HOLD_LAST) begin
            w_state_next = S_WAIT_ACT;
          end else begin
            w_hold_next = r_hold_cnt + 1'b1;
          end
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_heartbeat  <= 1'b0;
      r_alive      <= 1'b0;
      r_hb_count   <= '0;
      r_period_cnt <= '0;
      r_idle_cnt   <= '0;
      r_hold_cnt   <= '0;
    end else begin
      r_state      <= w_state_next;
      r_heartbeat  <= w_hb_next;
      r_alive      <= (w_state_next == S_ALIVE);
      r_hb_count   <= r_hb_count + 16'(w_hb_next);
      r_period_cnt <= w_period_next;
      r_idle_cnt   <= w_idle_next;
      r_hold_cnt   <= w_hold_next;
    end
  end

  assign heartbeat = r_heartbeat;
  assign alive     = r_alive;
  assign state     = r_state;
  assign hb_count  = r_hb_count;

endmodule

// File: tb/tb_heartbeat_generator.sv
// Self-checking bench for heartbeat_generator: vector table, directed corner
// sequences and randomized traffic against a timestamp-based reference model.
module tb_heartbeat_generator;

  localparam int P = 4;
  localparam int T = 10;
  localparam int H = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        activity = 1'b0;
  logic        force_reset = 1'b0;
  logic        heartbeat;
  logic        alive;
  logic [1:0]  state;
  logic [15:0] hb_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: tracks edge timestamps rather than counters.
  int m_state;
  int m_hb;
  int m_cnt;
  int m_edge;
  int m_entry;
  int m_last_act;
  int m_hold_start;

  heartbeat_generator #(.HB_PERIOD(P), .ACT_TIMEOUT(T), .HOLDOFF(H), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .enable(enable), .activity(activity),
    .force_reset(force_reset), .heartbeat(heartbeat), .alive(alive),
    .state(state), .hb_count(hb_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       en;
    bit       act;
    bit       fr;
    int       st;
    int       hb;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_tests++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act_v, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_hb = 0; m_cnt = 0; m_edge = 0;
    m_entry = 0; m_last_act = 0; m_hold_start = 0;
  endtask

  task automatic model_edge(input bit en, input bit act, input bit fr);
    m_edge++;
    m_hb = 0;
    if (!en) begin
      m_state = 0;
    end else if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      if (fr) begin
        m_state = 3; m_hold_start = m_edge;
      end else if (act) begin
        m_state = 2; m_entry = m_edge; m_last_act = m_edge; m_hb = 1;
      end
    end else if (m_state == 2) begin
      if (fr) begin
        m_state = 3; m_hold_start = m_edge;
      end else if (!act && (m_edge - m_last_act) == T) begin
        m_state = 1;
      end else begin
        if (act) m_last_act = m_edge;
        m_hb = ((m_edge - m_entry) % P == 0) ? 1 : 0;
      end
    end else begin
      if (fr) m_hold_start = m_edge;
      else if (m_edge - m_hold_start == H) m_state = 1;
    end
    m_cnt = (m_cnt + m_hb) % 65536;
  endtask

  // Drive at a negedge, clock once, compare at the following negedge.
  task automatic step(input bit en, input bit act, input bit fr);
    enable = en; activity = act; force_reset = fr;
    @(posedge clk);
    model_edge(en, act, fr);
    @(negedge clk);
    chk("state", 32'(state), 32'(m_state));
    chk("heartbeat", 32'(heartbeat), 32'(m_hb));
    chk("alive", 32'(alive), (m_state == 2) ? 32'd1 : 32'd0);
    chk("hb_count", 32'(hb_count), 32'(m_cnt));
  endtask

  initial begin
    model_reset();
    // Single activity: entry pulse then pulses every P, timeout after T idle edges.
    tbl[0]  = '{1, 0, 0, 1, 0};
    tbl[1]  = '{1, 1, 0, 2, 1};
    tbl[2]  = '{1, 0, 0, 2, 0};
    tbl[3]  = '{1, 0, 0, 2, 0};
    tbl[4]  = '{1, 0, 0, 2, 0};
    tbl[5]  = '{1, 0, 0, 2, 1};
    tbl[6]  = '{1, 0, 0, 2, 0};
    tbl[7]  = '{1, 0, 0, 2, 0};
    tbl[8]  = '{1, 0, 0, 2, 0};
    tbl[9]  = '{1, 0, 0, 2, 1};
    tbl[10] = '{1, 0, 0, 2, 0};
    tbl[11] = '{1, 0, 0, 1, 0};
    tbl[12] = '{1, 0, 0, 1, 0};

    repeat (2) @(negedge clk);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_hb", 32'(heartbeat), 32'd0);
    chk("reset_cnt", 32'(hb_count), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].en, tbl[i].act, tbl[i].fr);
      chk($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].st));
      chk($sformatf("tbl%0d_hb", i), 32'(heartbeat), 32'(tbl[i].hb));
    end
    chk("single_cnt", 32'(hb_count), 32'd3);

    // Sustained activity every 3 cycles: 10 pulses in 40 cycles.
    step(1, 1, 0);
    for (int i = 1; i < 40; i++) step(1, (i % 3) == 0, 0);
    chk("sustain_state", 32'(state), 32'd2);
    chk("sustain_cnt", 32'(hb_count), 32'd13);

    // Watchdog reset with extension mid-holdoff; activity held high throughout.
    step(1, 1, 1); chk("hold0", 32'(state), 32'd3); chk("hold0_hb", 32'(heartbeat), 32'd0);
    step(1, 1, 0); chk("hold1", 32'(state), 32'd3);
    step(1, 1, 1); chk("hold_ext", 32'(state), 32'd3);
    step(1, 1, 0); chk("hold_ext1", 32'(state), 32'd3);
    step(1, 1, 0); chk("hold_ext2", 32'(state), 32'd3);
    step(1, 1, 0); chk("hold_exit", 32'(state), 32'd1); chk("hold_exit_hb", 32'(heartbeat), 32'd0);
    step(1, 1, 0); chk("post_hold", 32'(state), 32'd2); chk("post_hold_hb", 32'(heartbeat), 32'd1);

    // Enable drop one cycle before the scheduled pulse.
    step(1, 0, 0); step(1, 0, 0);
    step(0, 0, 0); chk("drop_state", 32'(state), 32'd0); chk("drop_hb", 32'(heartbeat), 32'd0);
    step(1, 0, 0); chk("reen_state", 32'(state), 32'd1);
    repeat (5) step(1, 0, 0);
    chk("reen_cnt", 32'(hb_count), 32'd14);

    // Timeout coinciding with period expiry: no pulse, back to WAIT_ACT.
    step(1, 1, 0); step(1, 0, 0); step(1, 1, 0);
    repeat (9) step(1, 0, 0);
    step(1, 0, 0);
    chk("coinc_state", 32'(state), 32'd1);
    chk("coinc_hb", 32'(heartbeat), 32'd0);
    chk("coinc_cnt", 32'(hb_count), 32'd17);

    // Activity in the timeout cycle keeps ALIVE; pulses continue.
    step(1, 1, 0);
    repeat (9) step(1, 0, 0);
    step(1, 1, 0); chk("late_act_state", 32'(state), 32'd2);
    step(1, 0, 0); step(1, 0, 0);
    chk("late_act_hb", 32'(heartbeat), 32'd1);
    chk("late_act_cnt", 32'(hb_count), 32'd21);

    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 19) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 39) == 0);

    // Asynchronous reset mid-cycle from ALIVE.
    step(1, 0, 0); step(1, 1, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_hb", 32'(heartbeat), 32'd0);
    chk("arst_alive", 32'(alive), 32'd0);
    chk("arst_cnt", 32'(hb_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1, 0, 0); step(1, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
